// File: rtl/bldc_pkg.sv
// Shared types and hall decoding for the six-step BLDC commutator.
// BRAKE is only reachable in builds that define BLDC_BRAKE_EN.
package bldc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEADTIME,
        DRIVE,
        FAULT,
        BRAKE
    } state_t;

    typedef logic [2:0] step_t;

    localparam step_t STEP_NONE = 3'd7;

    // One-hot phase vectors, bit 0 = A, bit 1 = B, bit 2 = C
    typedef struct packed {
        logic [2:0] hi;
        logic [2:0] lo;
    } phase_pair_t;

    function automatic step_t hall_to_step(input logic [2:0] code);
        step_t s;
        case (code)
            3'b001:  s = 3'd0;
            3'b011:  s = 3'd1;
            3'b010:  s = 3'd2;
            3'b110:  s = 3'd3;
            3'b100:  s = 3'd4;
            3'b101:  s = 3'd5;
            default: s = STEP_NONE;
        endcase
        return s;
    endfunction

    function automatic phase_pair_t hall_to_phases(input logic [2:0] code,
                                                   input logic dir);
        phase_pair_t p;
        case (code)
            3'b001:  p = '{hi: 3'b001, lo: 3'b010};
            3'b011:  p = '{hi: 3'b001, lo: 3'b100};
            3'b010:  p = '{hi: 3'b010, lo: 3'b100};
            3'b110:  p = '{hi: 3'b010, lo: 3'b001};
            3'b100:  p = '{hi: 3'b100, lo: 3'b001};
            3'b101:  p = '{hi: 3'b100, lo: 3'b010};
            default: p = '{hi: 3'b000, lo: 3'b000};
        endcase
        if (dir) begin
            p = '{hi: p.lo, lo: p.hi};
        end
        return p;
    endfunction

endpackage

// File: rtl/hall_filter.sv
// Two-flop hall synchronizer followed by a stability filter that accepts
// a code only after SAMPLES identical consecutive synchronized samples.
module hall_filter #(
    parameter int SAMPLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] hall,
    output logic [2:0] code,
    output logic       valid
);

    localparam int CW = $clog2(SAMPLES + 1);

    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    cand;
    logic [CW-1:0] run;
    logic [CW-1:0] run_next;

    // Length of the current run of identical samples, saturating at SAMPLES
    always_comb begin
        run_next = CW'(1);
        if (sync2 == cand) begin
            run_next = (run == CW'(SAMPLES)) ? run : run + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            cand  <= '0;
            run   <= '0;
            code  <= '0;
            valid <= 1'b0;
        end else begin
            sync1 <= hall;
            sync2 <= sync1;
            cand  <= sync2;
            run   <= run_next;
            if (run_next >= CW'(SAMPLES)) begin
                code  <= sync2;
                valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/bldc_commutator.sv
// Six-step trapezoidal BLDC commutator with dead time and latched fault.
// Define BLDC_BRAKE_EN to add the brake input and the low-side BRAKE state.
module bldc_commutator #(
    parameter int PWM_BITS        = 10,
    parameter int DEADTIME_CYCLES = 16,
    parameter int HALL_FILTER     = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                direction,
    input  logic [PWM_BITS-1:0] duty,
    input  logic [2:0]          hall,
    input  logic                fault_n,
    input  logic                fault_clear,
`ifdef BLDC_BRAKE_EN
    input  logic                brake,
`endif
    output logic                inha,
    output logic                inla,
    output logic                inhb,
    output logic                inlb,
    output logic                inhc,
    output logic                inlc,
    output logic                fault_latched,
    output logic                hall_error,
    output logic [2:0]          step,
    output logic                period_start
);

    import bldc_pkg::*;

    localparam int          DW      = $clog2(DEADTIME_CYCLES + 1);
    localparam logic [DW-1:0] DT_LOAD = DW'(DEADTIME_CYCLES - 1);

    state_t              state;
    state_t              state_next;
    logic [DW-1:0]       dcnt;
    logic [DW-1:0]       dcnt_next;
    step_t               ref_step;
    logic                ref_dir;
    logic                fault_s1;
    logic                fault_s;
    logic [PWM_BITS-1:0] carrier;
    logic [PWM_BITS-1:0] carrier_next;
    logic [PWM_BITS-1:0] duty_l;
    logic [PWM_BITS-1:0] duty_next;
    logic                pwm_next;
    logic [2:0]          hall_code;
    logic                hall_seen;
    logic                hall_bad;
    logic                hall_ok;
    step_t               hall_step;
    phase_pair_t         pair;
    logic [2:0]          gate_hi;
    logic [2:0]          gate_lo;
    logic [2:0]          hi_next;
    logic [2:0]          lo_next;
    step_t               step_next;

    hall_filter #(
        .SAMPLES(HALL_FILTER)
    ) u_hall_filter (
        .clk   (clk),
        .reset (reset),
        .hall  (hall),
        .code  (hall_code),
        .valid (hall_seen)
    );

    assign hall_bad   = (hall_code == 3'b000) || (hall_code == 3'b111);
    assign hall_ok    = hall_seen && !hall_bad;
    assign hall_error = hall_seen && hall_bad;
    assign hall_step  = hall_to_step(hall_code);
    assign pair       = hall_to_phases(hall_code, direction);

    // Gates are registered from next-cycle values, so duty is taken at the wrap
    assign carrier_next = carrier + 1'b1;
    assign duty_next    = (carrier_next == '0) ? duty : duty_l;
    assign pwm_next     = carrier_next < duty_next;

    always_comb begin
        state_next = state;
        dcnt_next  = dcnt;
        if (!fault_s) begin
            state_next = FAULT;
        end else begin
            unique case (state)
                IDLE: begin
`ifdef BLDC_BRAKE_EN
                    if (brake) begin
                        state_next = DEADTIME;
                        dcnt_next  = DT_LOAD;
                    end else
`endif
                    if (enable && hall_ok) begin
                        state_next = DEADTIME;
                        dcnt_next  = DT_LOAD;
                    end
                end
                DEADTIME: begin
`ifdef BLDC_BRAKE_EN
                    if (brake) begin
                        if (dcnt == '0) state_next = BRAKE;
                        else            dcnt_next  = dcnt - 1'b1;
                    end else
`endif
                    if (!enable || !hall_ok) begin
                        state_next = IDLE;
                    end else if (hall_step != ref_step) begin
                        dcnt_next = DT_LOAD;
                    end else if (dcnt == '0) begin
                        state_next = DRIVE;
                    end else begin
                        dcnt_next = dcnt - 1'b1;
                    end
                end
                DRIVE: begin
`ifdef BLDC_BRAKE_EN
                    if (brake) begin
                        state_next = DEADTIME;
                        dcnt_next  = DT_LOAD;
                    end else
`endif
                    if (!enable || !hall_ok) begin
                        state_next = IDLE;
                    end else if (hall_step != ref_step ||
                                 direction != ref_dir) begin
                        state_next = DEADTIME;
                        dcnt_next  = DT_LOAD;
                    end
                end
                FAULT: begin
                    if (fault_clear) state_next = IDLE;
                end
`ifdef BLDC_BRAKE_EN
                BRAKE: begin
                    if (!brake) begin
                        state_next = DEADTIME;
                        dcnt_next  = DT_LOAD;
                    end
                end
`endif
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        hi_next   = 3'b000;
        lo_next   = 3'b000;
        step_next = STEP_NONE;
        if (state_next == DRIVE) begin
            hi_next   = pair.hi & {3{pwm_next}};
            lo_next   = pair.lo;
            step_next = hall_step;
        end
`ifdef BLDC_BRAKE_EN
        if (state_next == BRAKE) lo_next = 3'b111;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            dcnt          <= '0;
            ref_step      <= STEP_NONE;
            ref_dir       <= 1'b0;
            fault_s1      <= 1'b1;
            fault_s       <= 1'b1;
            carrier       <= '0;
            duty_l        <= '0;
            period_start  <= 1'b0;
            gate_hi       <= 3'b000;
            gate_lo       <= 3'b000;
            step          <= STEP_NONE;
            fault_latched <= 1'b0;
        end else begin
            state         <= state_next;
            dcnt          <= dcnt_next;
            ref_step      <= hall_step;
            ref_dir       <= direction;
            fault_s1      <= fault_n;
            fault_s       <= fault_s1;
            carrier       <= carrier_next;
            duty_l        <= duty_next;
            period_start  <= (carrier_next == '0);
            gate_hi       <= hi_next;
            gate_lo       <= lo_next;
            step          <= step_next;
            fault_latched <= (state_next == FAULT);
        end
    end

    assign inha = gate_hi[0];
    assign inhb = gate_hi[1];
    assign inhc = gate_hi[2];
    assign inla = gate_lo[0];
    assign inlb = gate_lo[1];
    assign inlc = gate_lo[2];

endmodule
